// File: rtl/video_axis_pkg.sv
`default_nettype none
// ============================================================================
// Module  : video_axis_pkg
// Brief   : Shared types and error-bit indices for the AXI4-Stream video receiver.
// Revision: 1.0 - initial release
// ============================================================================
package video_axis_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        RESYNC   = 2'd2
    } rx_state_t;

    localparam int ERR_NO_SOF    = 0;
    localparam int ERR_EARLY_EOL = 1;
    localparam int ERR_LATE_EOL  = 2;
    localparam int ERR_BAD_SOF   = 3;

endpackage
`default_nettype wire

// File: rtl/axis_video_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : axis_video_rx_if
// Brief   : AXI4-Stream video beat bundle (tdata/tvalid/tlast/tuser/tready).
// Revision: 1.0 - initial release
// ============================================================================
interface axis_video_rx_if #(
    parameter int N = 8
);
    logic [N-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tuser;
    logic         s_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating event counter; a clear coinciding with events keeps them.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [1:0]       inc,
    input  wire logic             clr,
    output logic      [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_sum;

    assign w_sum = {1'b0, r_cnt} + (CNT_W+1)'(inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= CNT_W'(inc);
        end else if (w_sum[CNT_W]) begin
            r_cnt <= '1;
        end else begin
            r_cnt <= w_sum[CNT_W-1:0];
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/axis_video_rx.sv
`default_nettype none
// ============================================================================
// Module  : axis_video_rx
// Brief   : AXI4-Stream video sink: tracks pixel x/y, forwards in-frame pixels
//           and flags framing faults with sticky flags and an error counter.
// Revision: 1.0 - initial release
// ============================================================================
module axis_video_rx
    import video_axis_pkg::*;
#(
    parameter int N      = 8,
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int CNT_W  = 16
) (
    input  wire logic                      sys_clk,
    input  wire logic                      sys_areset,
    input  wire logic                      en,
    axis_video_rx_if.slave                 s_axis,
    output logic [N-1:0]                   pix_data,
    output logic                           pix_valid,
    output logic [$clog2(WIDTH)-1:0]       pix_x,
    output logic [$clog2(HEIGHT)-1:0]      pix_y,
    output logic                           pix_eol,
    output logic                           pix_eof,
    output logic [CNT_W-1:0]               frame_cnt,
    output logic [3:0]                     err_flags,
    output logic [CNT_W-1:0]               err_cnt,
    input  wire logic                      err_clr
);

    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(HEIGHT);
    localparam logic [X_W-1:0] c_x_last = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] c_y_last = Y_W'(HEIGHT - 1);

    rx_state_t        r_state,   w_state_nx;
    logic [X_W-1:0]   r_x,       w_x_nx,  w_cx;
    logic [Y_W-1:0]   r_y,       w_y_nx,  w_cy;
    logic             r_drop_run, w_drop_run_nx;
    logic             w_accept, w_out, w_eol, w_end_line, w_eof, w_frame_done;
    logic [3:0]       w_err;
    logic [1:0]       w_inc;

    logic [N-1:0]     r_pix_data;
    logic             r_pix_valid, r_pix_eol, r_pix_eof;
    logic [X_W-1:0]   r_pix_x;
    logic [Y_W-1:0]   r_pix_y;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [3:0]       r_err_flags;

    assign s_axis.s_axis_tready = en;
    assign w_accept = s_axis.s_axis_tvalid & en;

    // A tuser beat first rebases the coordinates to (0,0); the same beat is
    // then handled as an ordinary in-line pixel, so tuser+tlast ends line 0.
    always_comb begin
        w_state_nx    = r_state;
        w_x_nx        = r_x;
        w_y_nx        = r_y;
        w_cx          = r_x;
        w_cy          = r_y;
        w_drop_run_nx = r_drop_run;
        w_out         = 1'b0;
        w_eol         = 1'b0;
        w_end_line    = 1'b0;
        w_eof         = 1'b0;
        w_frame_done  = 1'b0;
        w_err         = 4'b0000;
        if (w_accept) begin
            if (s_axis.s_axis_tuser) begin
                w_cx          = '0;
                w_cy          = '0;
                w_drop_run_nx = 1'b0;
                if (r_state != WAIT_SOF && (r_x != '0 || r_y != '0)) begin
                    w_err[ERR_BAD_SOF] = 1'b1;
                end
            end
            if (r_state == WAIT_SOF && !s_axis.s_axis_tuser) begin
                w_err[ERR_NO_SOF] = 1'b1;
                w_drop_run_nx     = 1'b1;
            end else if (r_state == RESYNC && !s_axis.s_axis_tuser) begin
                w_end_line = s_axis.s_axis_tlast;
            end else begin
                w_out      = 1'b1;
                w_state_nx = ACTIVE;
                if (w_cx == c_x_last) begin
                    w_eol = 1'b1;
                    if (s_axis.s_axis_tlast) begin
                        w_end_line = 1'b1;
                    end else begin
                        w_err[ERR_LATE_EOL] = 1'b1;
                        w_state_nx          = RESYNC;
                        w_x_nx              = w_cx;
                        w_y_nx              = w_cy;
                    end
                end else if (s_axis.s_axis_tlast) begin
                    w_eol                = 1'b1;
                    w_end_line           = 1'b1;
                    w_err[ERR_EARLY_EOL] = 1'b1;
                end else begin
                    w_x_nx = w_cx + 1'b1;
                    w_y_nx = w_cy;
                end
            end
            if (w_end_line) begin
                w_x_nx = '0;
                if (w_cy == c_y_last) begin
                    w_y_nx       = '0;
                    w_state_nx   = WAIT_SOF;
                    w_frame_done = 1'b1;
                    w_eof        = w_out;
                end else begin
                    w_y_nx     = w_cy + 1'b1;
                    w_state_nx = ACTIVE;
                end
            end
        end
        // A discard run counts once, on its first beat.
        w_inc = 2'(w_err[ERR_BAD_SOF]) + 2'(w_err[ERR_EARLY_EOL]) +
                2'(w_err[ERR_LATE_EOL]) + 2'(w_err[ERR_NO_SOF] & ~r_drop_run);
    end

    always_ff @(posedge sys_clk or posedge sys_areset) begin
        if (sys_areset) begin
            r_state     <= WAIT_SOF;
            r_x         <= '0;
            r_y         <= '0;
            r_drop_run  <= 1'b0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_eol   <= 1'b0;
            r_pix_eof   <= 1'b0;
            r_frame_cnt <= '0;
            r_err_flags <= 4'b0000;
        end else begin
            r_state     <= w_state_nx;
            r_x         <= w_x_nx;
            r_y         <= w_y_nx;
            r_drop_run  <= w_drop_run_nx;
            r_pix_valid <= w_out;
            r_pix_eol   <= w_out & w_eol;
            r_pix_eof   <= w_eof;
            if (w_out) begin
                r_pix_data <= s_axis.s_axis_tdata;
                r_pix_x    <= w_cx;
                r_pix_y    <= w_cy;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            r_err_flags <= (err_clr ? 4'b0000 : r_err_flags) | w_err;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk (sys_clk),
        .rst (sys_areset),
        .inc (w_inc),
        .clr (err_clr),
        .cnt (err_cnt)
    );

    assign pix_data  = r_pix_data;
    assign pix_valid = r_pix_valid;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_eol   = r_pix_eol;
    assign pix_eof   = r_pix_eof;
    assign frame_cnt = r_frame_cnt;
    assign err_flags = r_err_flags;

endmodule
`default_nettype wire

// File: tb/tb_axis_video_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_video_rx
// Brief   : Directed self-checking bench for axis_video_rx (10x10 frames).
// Revision: 1.0 - initial release
// ============================================================================
module tb_axis_video_rx;

    logic        clk;
    logic        rst;
    logic        en;
    logic        err_clr;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic [3:0]  pix_x;
    logic [3:0]  pix_y;
    logic        pix_eol;
    logic        pix_eof;
    logic [15:0] frame_cnt;
    logic [3:0]  err_flags;
    logic [15:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [17:0] obs_q[$];

    axis_video_rx_if #(.N(8)) s_axis ();

    axis_video_rx #(
        .N      (8),
        .WIDTH  (10),
        .HEIGHT (10),
        .CNT_W  (16)
    ) dut (
        .sys_clk    (clk),
        .sys_areset (rst),
        .en         (en),
        .s_axis     (s_axis),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .frame_cnt  (frame_cnt),
        .err_flags  (err_flags),
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] pk(input int x, input int y, input bit eol,
                                       input bit eof, input logic [7:0] d);
        return {eof, eol, 4'(y), 4'(x), d};
    endfunction

    function automatic logic [7:0] dat(input int x, input int y);
        return 8'(y * 16 + x);
    endfunction

    always @(negedge clk) begin
        if (pix_valid) obs_q.push_back(pk(int'(pix_x), int'(pix_y), pix_eol, pix_eof, pix_data));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_pix(input int idx, input int x, input int y, input bit eol,
                           input bit eof, input logic [7:0] d);
        if (idx < obs_q.size()) chk($sformatf("pix%0d", idx), 32'(obs_q[idx]), 32'(pk(x, y, eol, eof, d)));
        else                    chk($sformatf("pix%0d_missing", idx), obs_q.size(), idx + 1);
    endtask

    task automatic drive(input logic [7:0] d, input logic u, input logic l);
        @(negedge clk);
        s_axis.s_axis_tdata  = d;
        s_axis.s_axis_tvalid = 1'b1;
        s_axis.s_axis_tuser  = u;
        s_axis.s_axis_tlast  = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_axis.s_axis_tvalid = 1'b0;
            s_axis.s_axis_tuser  = 1'b0;
            s_axis.s_axis_tlast  = 1'b0;
            err_clr              = 1'b0;
        end
    endtask

    // Reset asserted mid-cycle and checked before any clock edge.
    task automatic do_reset(input string tag);
        idle(1);
        rst = 1'b1;
        #1;
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_pix"}, {pix_eol, pix_eof, pix_x, pix_y, pix_data}, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_err_flags"}, err_flags, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic send_frame(input bit with_sof, input int gap_pix, input int no_tlast_line);
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                if (y * 10 + x == gap_pix) idle(1);
                drive(dat(x, y), with_sof && x == 0 && y == 0, x == 9 && y != no_tlast_line);
            end
            if (y == no_tlast_line) begin
                drive(8'hEE, 1'b0, 1'b0);
                drive(8'hEE, 1'b0, 1'b0);
                drive(8'hEE, 1'b0, 1'b1);
            end
        end
        idle(3);
    endtask

    task automatic expect_frame(input int base);
        for (int i = 0; i < 100; i++)
            chk_pix(base + i, i % 10, i / 10, (i % 10) == 9, i == 99, dat(i % 10, i / 10));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end

    initial begin
        rst                  = 1'b1;
        en                   = 1'b0;
        err_clr              = 1'b0;
        s_axis.s_axis_tdata  = 8'h00;
        s_axis.s_axis_tvalid = 1'b0;
        s_axis.s_axis_tuser  = 1'b0;
        s_axis.s_axis_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        chk("tready_en0", s_axis.s_axis_tready, 0);
        en = 1'b1;
        #1;
        chk("tready_en1", s_axis.s_axis_tready, 1);
        do_reset("rst0");

        // Clean frame.
        send_frame(1'b1, -1, -1);
        chk("clean_count", obs_q.size(), 100);
        expect_frame(0);
        chk("clean_frame_cnt", frame_cnt, 1);
        chk("clean_err_flags", err_flags, 0);

        // Same frame with a one-cycle tvalid gap before pixel 2.
        obs_q.delete();
        send_frame(1'b1, 2, -1);
        chk("gap_count", obs_q.size(), 100);
        expect_frame(0);
        chk("gap_frame_cnt", frame_cnt, 2);
        chk("gap_err_flags", err_flags, 0);

        // One-cycle latency, then early tlast on pixel 7 of line 0.
        do_reset("rst1");
        drive(dat(0, 0), 1'b1, 1'b0);
        chk("lat_before", pix_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_after", pix_valid, 1);
        for (int x = 1; x < 8; x++) drive(dat(x, 0), 1'b0, x == 7);
        drive(dat(0, 1), 1'b0, 1'b0);
        drive(dat(1, 1), 1'b0, 1'b0);
        idle(3);
        chk("early_count", obs_q.size(), 10);
        for (int x = 0; x < 8; x++) chk_pix(x, x, 0, x == 7, 1'b0, dat(x, 0));
        chk_pix(8, 0, 1, 1'b0, 1'b0, dat(0, 1));
        chk("early_err_flags", err_flags, 4'b0010);
        chk("early_err_cnt", err_cnt, 1);

        // Reset mid-frame, then a frame with no tuser followed by a good one.
        do_reset("rst2");
        send_frame(1'b0, -1, -1);
        chk("nosof_discard", obs_q.size(), 0);
        send_frame(1'b1, -1, -1);
        chk("nosof_count", obs_q.size(), 100);
        expect_frame(0);
        chk("nosof_err_flags", err_flags, 4'b0001);
        chk("nosof_err_cnt", err_cnt, 1);
        chk("nosof_frame_cnt", frame_cnt, 1);

        // Missing tlast on line 3 with extra beats before the late tlast.
        do_reset("rst3");
        send_frame(1'b1, -1, 3);
        chk("late_count", obs_q.size(), 100);
        expect_frame(0);
        chk("late_err_flags", err_flags, 4'b0100);
        chk("late_err_cnt", err_cnt, 1);
        chk("late_frame_cnt", frame_cnt, 1);

        // Unexpected tuser at (5,6), restart, err_clr, en low, clr+error together.
        do_reset("rst4");
        for (int i = 0; i < 65; i++) drive(dat(i % 10, i / 10), i == 0, (i % 10) == 9);
        drive(8'hA5, 1'b1, 1'b0);
        for (int x = 1; x < 10; x++) drive(dat(x, 0), 1'b0, x == 9);
        idle(3);
        chk("badsof_count", obs_q.size(), 75);
        chk_pix(64, 4, 6, 1'b0, 1'b0, dat(4, 6));
        chk_pix(65, 0, 0, 1'b0, 1'b0, 8'hA5);
        chk_pix(66, 1, 0, 1'b0, 1'b0, dat(1, 0));
        chk_pix(74, 9, 0, 1'b1, 1'b0, dat(9, 0));
        chk("badsof_err_flags", err_flags, 4'b1000);
        chk("badsof_err_cnt", err_cnt, 1);
        chk("badsof_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        err_clr = 1'b1;
        idle(1);
        chk("clr_err_flags", err_flags, 0);
        chk("clr_err_cnt", err_cnt, 0);

        en = 1'b0;
        drive(dat(0, 1), 1'b0, 1'b1);
        #1;
        chk("en0_tready", s_axis.s_axis_tready, 0);
        repeat (3) @(negedge clk);
        chk("en0_no_output", obs_q.size(), 75);
        en      = 1'b1;
        err_clr = 1'b1;
        idle(3);
        chk("clrerr_count", obs_q.size(), 76);
        chk_pix(75, 0, 1, 1'b1, 1'b0, dat(0, 1));
        chk("clrerr_err_flags", err_flags, 4'b0010);
        chk("clrerr_err_cnt", err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_video_rx.md
Name: axis_video_rx

Overview:
AXI4-Stream video receiver/framing checker: the sink end of the team's video stream source. It accepts 8-bit pixel beats framed by tuser (start of frame) and tlast (end of line), and tracks pixel x/y. It forwards in-frame pixels with coordinates to the histogram/equalisation datapath and flags framing faults (missing tuser, early/missing tlast, unexpected tuser). It sits directly behind the stream input, ahead of the histogram accumulator.

Parameters:
N, 8, pixel data width
WIDTH, 10, active pixels per line
HEIGHT, 10, lines per frame
CNT_W, 16, width of frame and error counters

Ports:
sys_clk  in  1  clock, all logic on rising edge
sys_areset  in  1  asynchronous, active-high reset
en  in  1  receive enable; drives tready
s_axis_tdata  in  N  pixel data
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  end of line
s_axis_tuser  in  1  start of frame
s_axis_tready  out  1  = en (combinational, no other dependency)
pix_data  out  N  registered pixel
pix_valid  out  1  pixel strobe
pix_x  out  $clog2(WIDTH)  column of pix_data
pix_y  out  $clog2(HEIGHT)  row of pix_data
pix_eol  out  1  last pixel of line (x==WIDTH-1 or early-terminated line)
pix_eof  out  1  last pixel of frame
frame_cnt  out  CNT_W  completed frames, wraps
err_flags  out  4  sticky: [0] no_sof drop, [1] early tlast, [2] missing tlast, [3] unexpected tuser
err_cnt  out  CNT_W  error events, saturates at all-ones
err_clr  in  1  synchronous clear of err_flags and err_cnt

Behaviour:
- Beat accepted when s_axis_tvalid & s_axis_tready. tvalid gaps mid-line are legal and stall counters; no error.
- Reset: state=WAIT_SOF, x=y=0, all outputs 0, frame_cnt=0, err_flags=0, err_cnt=0.
- Latency: accepted in-frame beat appears on pix_* exactly 1 cycle later; pix_valid 1-cycle pulse per beat; discarded beats never produce pix_valid.
- FSM states WAIT_SOF, ACTIVE, RESYNC:
- WAIT_SOF: beat with tuser=1 -> output as (0,0), x=1, go ACTIVE. Beat with tuser=0 -> discard, set err_flags[0]; err_cnt +1 once per contiguous discard run, not per beat.
- ACTIVE, beat tuser=0:
  - x<WIDTH-1, tlast=0: output, x++.
  - x<WIDTH-1, tlast=1: early tlast. Output with pix_eol=1, set flag[1], err_cnt+1, end line.
  - x==WIDTH-1, tlast=1: normal line end; output with pix_eol=1, end line.
  - x==WIDTH-1, tlast=0: missing tlast. Output with pix_eol=1, set flag[2], err_cnt+1, go RESYNC.
- End line: x=0. If y==HEIGHT-1: pix_eof=1 on same output cycle, frame_cnt+1, y=0, go WAIT_SOF. Else y++.
- ACTIVE, beat tuser=1 at (x,y)!=(0,0): unexpected tuser. Set flag[3], err_cnt+1, no eof, no frame_cnt change. Beat output as (0,0), x=1, y=0 (frame restart).
- RESYNC: discard beats until one with tlast=1 (discarded too), then apply end line. tuser=1 seen in RESYNC: restart-frame handling as above, go ACTIVE.
- tuser and tlast on same beat with WIDTH>1: tuser handling first, then early tlast at x=0.
- Simultaneous err_clr and new error: the new error wins (flag set, err_cnt=1).
- en low: tready=0, no beats accepted, state held. Reset mid-frame: immediate return to reset values.

Decomposition:
- Package video_axis_pkg:
  - state enum rx_state_t {WAIT_SOF, ACTIVE, RESYNC}
  - error bit index constants ERR_NO_SOF=0, ERR_EARLY_EOL=1, ERR_LATE_EOL=2, ERR_BAD_SOF=3
- One sub-module: sat_counter (CNT_W, inc, clr), used for err_cnt.

Test Plan:
- Clean 10x10 frame, en=1, continuous tvalid -> 100 pix_valid pulses; eol at x=9 on each row; single eof at (9,9); frame_cnt=1; err_flags=0.
- Same frame with tvalid low for 1 cycle at pixel 2 of line 0 -> identical pix_* sequence, only delayed; err_flags=0.
- tlast on pixel 7 of line 0 -> eol at x=7,y=0; next beat is (0,1); err_flags=4'b0010; err_cnt=1.
- Frame with no tuser, then valid frame -> first 100 beats discarded, flag[0] set, err_cnt=1; second frame delivers 100 pixels, frame_cnt=1.
- tlast missing on line 3, 2 extra beats before tlast -> eol at (9,3); extra beats discarded; next output is (0,4); flag[2] set.
- tuser at (5,6), then err_clr -> restart at (0,0), flag[3]=1, err_cnt=1; after err_clr, err_flags=0 and err_cnt=0.
